sd_sector_writer: RTL
=====================

Name: sd_sector_writer

Overview:
- Write-back engine for floppy images: core-to-SD direction of the MiST user_io sector interface, complementing the existing sector read path.
- The core fills a 512-byte staging buffer, then issues a write request for a drive and LBA.
- The block raises sd_wr, serves bytes on sd_din as user_io walks sd_buff_addr, and reports completion or error.
- Sits in the top level between tvctop's disk controller and user_io; shares sd_lba with the read path through an external mux that is owned by the instantiating logic.

Parameters:
- TIMEOUT_CYCLES, 50000000: max clk_sys cycles from request to sd_ack rise (1 s at 50 MHz).
- NUM_DRIVES, 2: drives; sets width of sd_wr, img_mounted and img_wp.

Ports:
- clk_sys in 1: system clock (CLK_50M).
- reset in 1: synchronous, active-high.
- buf_addr in 9: core-side staging buffer address.
- buf_data in 8: core-side write data.
- buf_we in 1: core buffer write strobe; ignored while busy=1.
- wr_req in 1: single-cycle request pulse.
- wr_drive in 1: target drive index, sampled on wr_req.
- wr_lba in 32: target sector, sampled on wr_req.
- busy out 1: request in progress.
- done out 1: one-cycle pulse, sector written.
- error out 2: 0=none, 1=timeout, 2=write-protected, 3=not mounted; valid with done.
- img_mounted in NUM_DRIVES: mount pulse per drive from user_io.
- img_size in 32: size of the image just mounted.
- img_wp in NUM_DRIVES: write-protect per drive.
- sd_lba out 32: sector address to user_io.
- sd_wr out NUM_DRIVES: write request per drive.
- sd_ack in 1: user_io transfer acknowledge.
- sd_buff_addr in 9: byte index requested by user_io.
- sd_din out 8: byte to user_io.
- sd_din_strobe in 1: byte consumed.

Behaviour:
- Reset values: busy=0, done=0, error=0, sd_wr=0, sd_lba=0, sd_din=0, state=IDLE. Mounted flags clear. Buffer contents are not reset.
- Mounted flags: on img_mounted[d], mounted[d] <= (img_size != 0). Writes to mounted[d] while a request for d is active take effect only on the next request.
- IDLE: buf_we writes buf[buf_addr].
  - On wr_req, latch drive and LBA; sd_lba <= wr_lba.
  - If ~mounted[drive]: go to FIN with error=3.
  - Else if img_wp[drive]: go to FIN with error=2.
  - Else: go to REQ with sd_wr[drive]=1 and busy=1 from the next cycle.
- REQ: hold sd_wr and sd_lba; increment the timeout counter.
  - On sd_ack rising: deassert sd_wr next cycle and go to XFER.
  - If the counter reaches TIMEOUT_CYCLES-1 first: sd_wr=0, go to FIN with error=1.
- XFER: sd_din <= buf[sd_buff_addr], registered. Valid one cycle after sd_buff_addr changes; registered on every cycle while sd_ack=1.
  - Count sd_din_strobe pulses mod 512.
  - On sd_ack falling: go to FIN with error=0, regardless of strobe count. A short transfer is not an error; the strobe count is observable for verification only.
- FIN: done=1 for one cycle, error held; busy=0 next cycle; return to IDLE.
  - error holds its value until the next wr_req.
- wr_req while busy: ignored, no queueing.
- wr_req coincident with buf_we in IDLE: buffer write is accepted and the request starts. The byte is visible to the transfer because user_io cannot read earlier than 2 cycles later.
- sd_ack already high at request: not treated as a rising edge; wait for the ack to fall then rise.
- Reset mid-transfer: immediate return to IDLE, sd_wr=0, no done pulse.
- Drive index out of range (≥ NUM_DRIVES): treated as not mounted.

Decomposition:
- Package sd_pkg:
  - state enum {IDLE, REQ, XFER, FIN}
  - SECTOR_BYTES=512
  - error code constants ERR_NONE, ERR_TIMEOUT, ERR_WP, ERR_NOMOUNT
- Sub-module sector_buf_dp: 512x8 simple dual-port RAM.
  - Port A: write, core side.
  - Port B: registered read, sd_buff_addr side.
  - Maps to one M9K.

Test Plan:
- Fill buffer with buf[i]=i^8'hA5; mount drive 0 (size 737280); wr_req drive 0, lba 32'h12 -> sd_wr=2'b01 and sd_lba=32'h12. User_io model acks after 20 cycles and walks addr 0..511 with strobes -> model receives i^A5 for all 512 bytes; sd_wr low 1 cycle after ack rise; done pulse with error=0.
- Request on drive 1 never mounted -> done within 2 cycles, error=3, sd_wr never asserted.
- Mount drive 1 with img_wp[1]=1, request drive 1 -> error=2, no sd_wr.
- TIMEOUT_CYCLES=100, model never acks -> sd_wr high for exactly 100 cycles, then done with error=1. A second request then succeeds normally.
- Assert reset at byte 200 of a transfer -> sd_wr=0, busy=0 next cycle, no done pulse. A following request completes with full data.
- wr_req pulsed again while busy, and buf_we attempted while busy -> second request ignored; buffer unchanged; data read back in the next transfer matches the pre-busy contents.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector write-back path.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    FIN
  } state_t;

  localparam int SECTOR_BYTES = 512;
  localparam int ADDR_W       = $clog2(SECTOR_BYTES);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_WP      = 2'd2;
  localparam logic [1:0] ERR_NOMOUNT = 2'd3;

endpackage

// File: rtl/sector_buf_dp.sv
// 512x8 simple dual-port staging RAM: port A writes from the core,
// port B is a registered read toward user_io.
module sector_buf_dp
  import sd_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [SECTOR_BYTES];
  logic [7:0] rd_data_reg;

  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is cleared; array contents survive reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sd_sector_writer.sv
// Core-to-SD sector write engine for the user_io sector interface: stages one
// sector, raises sd_wr for the target drive and serves bytes on sd_din.
module sd_sector_writer
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int NUM_DRIVES     = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [8:0]            buf_addr,
  input  logic [7:0]            buf_data,
  input  logic                  buf_we,
  input  logic                  wr_req,
  input  logic                  wr_drive,
  input  logic [31:0]           wr_lba,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error,
  input  logic [NUM_DRIVES-1:0] img_mounted,
  input  logic [31:0]           img_size,
  input  logic [NUM_DRIVES-1:0] img_wp,
  output logic [31:0]           sd_lba,
  output logic [NUM_DRIVES-1:0] sd_wr,
  input  logic                  sd_ack,
  input  logic [8:0]            sd_buff_addr,
  output logic [7:0]            sd_din,
  input  logic                  sd_din_strobe
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [NUM_DRIVES-1:0]   sd_wr_reg, sd_wr_next;
  logic [31:0]             sd_lba_reg, sd_lba_next;
  logic [1:0]              error_reg, error_next;
  logic                    done_reg, done_next;
  logic                    busy_reg, busy_next;
  logic [CNT_W-1:0]        tmo_cnt_reg, tmo_cnt_next;
  logic [ADDR_W-1:0]       strobe_cnt_reg, strobe_cnt_next;
  logic                    ack_prev_reg;

  logic [NUM_DRIVES-1:0]   mounted_reg;
  logic [NUM_DRIVES-1:0]   drv_onehot;
  logic                    drv_mounted;
  logic                    drv_wp;
  logic                    ack_rise;
  logic                    ack_fall;
  logic                    buf_wr_en;
  logic                    buf_rd_en;

  // Per-drive mount flag and drive decode; an out-of-range index decodes to
  // no drive at all and therefore reads as not mounted.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DRIVES; gi++) begin : g_drive
      logic mounted_q_reg;

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          mounted_q_reg <= 1'b0;
        end else if (img_mounted[gi]) begin
          mounted_q_reg <= (img_size != 32'd0);
        end
      end

      assign mounted_reg[gi] = mounted_q_reg;
      assign drv_onehot[gi]  = ({31'd0, wr_drive} == 32'(gi));
    end
  endgenerate

  assign drv_mounted = |(drv_onehot & mounted_reg);
  assign drv_wp      = |(drv_onehot & img_wp);
  assign ack_rise    = sd_ack & ~ack_prev_reg;
  assign ack_fall    = ~sd_ack & ack_prev_reg;

  always_comb begin
    state_next      = state_reg;
    sd_wr_next      = sd_wr_reg;
    sd_lba_next     = sd_lba_reg;
    error_next      = error_reg;
    done_next       = 1'b0;
    tmo_cnt_next    = tmo_cnt_reg;
    strobe_cnt_next = strobe_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (wr_req) begin
          sd_lba_next     = wr_lba;
          tmo_cnt_next    = '0;
          strobe_cnt_next = '0;
          if (!drv_mounted) begin
            error_next = ERR_NOMOUNT;
            done_next  = 1'b1;
            state_next = FIN;
          end else if (drv_wp) begin
            error_next = ERR_WP;
            done_next  = 1'b1;
            state_next = FIN;
          end else begin
            error_next = ERR_NONE;
            sd_wr_next = drv_onehot;
            state_next = REQ;
          end
        end
      end

      // An ack that is already high on entry is not an edge: ack_prev_reg
      // tracks sd_ack in every state.
      REQ: begin
        if (ack_rise) begin
          sd_wr_next = '0;
          state_next = XFER;
        end else if (tmo_cnt_reg == CNT_LAST) begin
          sd_wr_next = '0;
          error_next = ERR_TIMEOUT;
          done_next  = 1'b1;
          state_next = FIN;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
        end
      end

      XFER: begin
        if (sd_din_strobe) begin
          strobe_cnt_next = strobe_cnt_reg + ADDR_W'(1);
        end
        if (ack_fall) begin
          error_next = ERR_NONE;
          done_next  = 1'b1;
          state_next = FIN;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= IDLE;
      sd_wr_reg      <= '0;
      sd_lba_reg     <= '0;
      error_reg      <= ERR_NONE;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      tmo_cnt_reg    <= '0;
      strobe_cnt_reg <= '0;
      ack_prev_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sd_wr_reg      <= sd_wr_next;
      sd_lba_reg     <= sd_lba_next;
      error_reg      <= error_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      strobe_cnt_reg <= strobe_cnt_next;
      ack_prev_reg   <= sd_ack;
    end
  end

  // A write coincident with wr_req still lands; user_io reads no earlier than
  // two cycles later, so the byte is visible to the transfer.
  assign buf_wr_en = buf_we && (state_reg == IDLE);
  assign buf_rd_en = sd_ack && ((state_reg == REQ) || (state_reg == XFER));

  sector_buf_dp u_buf (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_addr),
    .wr_data (buf_data),
    .rd_en   (buf_rd_en),
    .rd_addr (sd_buff_addr),
    .rd_data (sd_din)
  );

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign error  = error_reg;
  assign sd_wr  = sd_wr_reg;
  assign sd_lba = sd_lba_reg;

endmodule
